// File: rtl/mem_access_ctrl_if.sv
// Request/memory bundle between the address-select stage, the load/store
// engine and the byte-addressed data memory.
interface mem_access_ctrl_if;
  logic        start;
  logic        is_store;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        misalign;

  modport master (
    output start, is_store, size, sign_ext, addr, wdata, mem_rdata,
    input  mem_addr, mem_wdata, mem_wr, rdata, busy, done, misalign
  );

  modport slave (
    input  start, is_store, size, sign_ext, addr, wdata, mem_rdata,
    output mem_addr, mem_wdata, mem_wr, rdata, busy, done, misalign
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Multicycle load/store engine: word-aligned memory access, read-modify-write
// for sub-word stores, sign/zero-extended sub-word loads, misalignment fault.
module mem_access_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, FAULT} state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic [15:0] wdata_q, wdata_d;
  logic        store_q, store_d;
  logic        sext_q, sext_d;

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b01:   return a[0];
      2'b10:   return 1'b0;
      default: return a != 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] sz,
                                          input logic [1:0] lane, input logic sext);
    logic [31:0] sh;
    case (sz)
      2'b10: begin
        sh = word >> {lane, 3'b000};
        return {{24{sext & sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh = word >> {lane[1], 4'b0000};
        return {{16{sext & sh[15]}}, sh[15:0]};
      end
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [15:0] wd,
                                        input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] mask;
    logic [31:0] ins;
    if (sz == 2'b10) begin
      mask = 32'h0000_00FF << {lane, 3'b000};
      ins  = {24'h0, wd[7:0]} << {lane, 3'b000};
    end else begin
      mask = 32'h0000_FFFF << {lane[1], 4'b0000};
      ins  = {16'h0, wd} << {lane[1], 4'b0000};
    end
    return (old & ~mask) | (ins & mask);
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    lane_d      = lane_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    store_d     = store_q;
    sext_d      = sext_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          lane_d  = bus.addr[1:0];
          size_d  = bus.size;
          wdata_d = bus.wdata[15:0];
          store_d = bus.is_store;
          sext_d  = bus.sign_ext;
          cnt_d   = 3'd0;
          if (misaligned(bus.size, bus.addr[1:0])) begin
            state_d = FAULT;
          end else begin
            mem_addr_d = {bus.addr[31:2], 2'b00};
            // Full-word stores need no read of the old word.
            if (bus.is_store && (bus.size == 2'b00 || bus.size == 2'b11)) begin
              mem_wdata_d = bus.wdata;
              state_d     = WRITE;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        if (cnt_q == LAT) begin
          if (store_q) begin
            mem_wdata_d = merge(bus.mem_rdata, wdata_q, size_q, lane_q);
            state_d     = WRITE;
          end else begin
            rdata_d = extract(bus.mem_rdata, size_q, lane_q, sext_q);
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Captured request fields are only meaningful once an operation starts.
  always_ff @(posedge clk) begin
    lane_q  <= lane_d;
    size_q  <= size_d;
    wdata_q <= wdata_d;
    store_q <= store_d;
    sext_q  <= sext_d;
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wr    = (state_q == WRITE);
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE) || (state_q == FAULT);
  assign bus.misalign  = (state_q == FAULT);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: MEM_LAT=1 instance for directed
// loads/stores/faults/reset, MEM_LAT=3 instance for held-start back-to-back loads.
module tb_mem_access_ctrl;
  logic clk;
  logic reset;
  int   cyc;
  int   n_chk;
  int   n_pass;

  mem_access_ctrl_if bus ();
  mem_access_ctrl_if bus3 ();

  mem_access_ctrl #(.MEM_LAT(1)) dut  (.clk(clk), .reset(reset), .bus(bus));
  mem_access_ctrl #(.MEM_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  logic [31:0] mem [256];
  assign bus.mem_rdata  = mem[bus.mem_addr[9:2]];
  assign bus3.mem_rdata = bus3.mem_addr ^ 32'hA5A5_0000;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    int          cyc;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  exp_t exp_q[$];
  wr_t  wr_q[$];

  int   s3;
  int   n3;
  logic mon3_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr[9:2]] = bus.mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Main DUT monitor: pops expectations whenever done or mem_wr is seen.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("rdata", bus.rdata, e.rd);
        chk("misalign", {31'h0, bus.misalign}, {31'h0, e.mis});
      end
    end
    if (bus.mem_wr === 1'b1) begin
      if (wr_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got mem_wr=1 addr 0x%08h expected none (cycle %0d)",
                 bus.mem_addr, cyc);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("wr_cycle", 32'(cyc), 32'(w.cyc));
        chk("mem_addr", bus.mem_addr, w.addr);
        chk("mem_wdata", bus.mem_wdata, w.data);
      end
    end
  end

  // Held-start monitor: accept every 6 cycles, done 5 cycles after each accept.
  always @(negedge clk) begin
    if (mon3_en) begin
      chk("busy3", {31'h0, bus3.busy}, {31'h0, ((cyc - s3) % 6) != 0});
      if (bus3.done === 1'b1) begin
        chk("done3_cycle", 32'(cyc), 32'(s3 + 5 + 6 * n3));
        chk("rdata3", bus3.rdata, 32'hA5A5_0040);
        n3++;
      end
    end
  end

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (bus.busy && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k == 30) begin
      n_chk++;
      $display("FAIL %s_timeout: got busy after 30 cycles expected idle", name);
    end
  endtask

  task automatic op(input string name, input logic st, input logic [1:0] sz, input logic sx,
                    input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                    input logic mis, input int lat, input int wr_off, input logic [31:0] exp_wd);
    exp_t e;
    wr_t  w;
    bus.start    = 1'b1;
    bus.is_store = st;
    bus.size     = sz;
    bus.sign_ext = sx;
    bus.addr     = a;
    bus.wdata    = wd;
    e.rd  = exp_rd;
    e.mis = mis;
    e.cyc = cyc + lat;
    exp_q.push_back(e);
    if (wr_off >= 0) begin
      w.addr = {a[31:2], 2'b00};
      w.data = exp_wd;
      w.cyc  = cyc + wr_off;
      wr_q.push_back(w);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.addr  = 32'hFFFF_FFFF;
    bus.wdata = 32'hFFFF_FFFF;
    wait_idle(name);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; n3 = 0; s3 = 0; mon3_en = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[32'h100 >> 2] = 32'h80AB_CDEF;
    mem[32'h200 >> 2] = 32'h1111_2222;
    bus.start = 1'b0; bus.is_store = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0;
    bus3.start = 1'b0; bus3.is_store = 1'b0; bus3.size = 2'b00; bus3.sign_ext = 1'b0;
    bus3.addr = 32'h0000_0040; bus3.wdata = 32'h0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_done", {31'h0, bus.done}, 32'h0);
    chk("rst_misalign", {31'h0, bus.misalign}, 32'h0);
    chk("rst_mem_wr", {31'h0, bus.mem_wr}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);

    op("lb_sext",  1'b0, 2'b10, 1'b1, 32'h0000_0103, 32'h0, 32'hFFFF_FF80, 1'b0, 3, -1, 32'h0);
    op("lbu",      1'b0, 2'b10, 1'b0, 32'h0000_0103, 32'h0, 32'h0000_0080, 1'b0, 3, -1, 32'h0);
    op("sh",       1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_BEEF, 32'h0000_0080, 1'b0, 4, 3, 32'hBEEF_2222);
    op("sw",       1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0080, 1'b0, 2, 1, 32'hDEAD_BEEF);
    op("lw_mis",   1'b0, 2'b00, 1'b0, 32'h0000_0006, 32'h0, 32'h0000_0080, 1'b1, 1, -1, 32'h0);
    op("sh_mis",   1'b1, 2'b01, 1'b0, 32'h0000_0005, 32'h5555_AAAA, 32'h0000_0080, 1'b1, 1, -1, 32'h0);
    op("lh_sext",  1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 32'hFFFF_BEEF, 1'b0, 3, -1, 32'h0);
    op("lhu_low",  1'b0, 2'b01, 1'b0, 32'h0000_0200, 32'h0, 32'h0000_2222, 1'b0, 3, -1, 32'h0);
    op("sb_lane1", 1'b1, 2'b10, 1'b0, 32'h0000_0011, 32'h1234_5655, 32'h0000_2222, 1'b0, 4, 3, 32'hDEAD_55EF);
    op("lw_rsvd",  1'b0, 2'b11, 1'b1, 32'h0000_0010, 32'h0, 32'hDEAD_55EF, 1'b0, 3, -1, 32'h0);
    op("lb_lane2", 1'b0, 2'b10, 1'b1, 32'h0000_0012, 32'h0, 32'hFFFF_FFAD, 1'b0, 3, -1, 32'h0);

    // Byte store abandoned by reset while reading; no expectations queued.
    bus.start = 1'b1; bus.is_store = 1'b1; bus.size = 2'b10; bus.sign_ext = 1'b0;
    bus.addr = 32'h0000_0301; bus.wdata = 32'h0000_0077;
    @(posedge clk);
    #1 bus.start = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midrst_busy", {31'h0, bus.busy}, 32'h0);
    chk("midrst_mem_wr", {31'h0, bus.mem_wr}, 32'h0);
    chk("midrst_done", {31'h0, bus.done}, 32'h0);
    chk("midrst_rdata", bus.rdata, 32'h0);
    chk("midrst_mem_addr", bus.mem_addr, 32'h0);
    chk("midrst_mem_wdata", bus.mem_wdata, 32'h0);
    repeat (3) @(posedge clk);
    #1 chk("midrst_mem_untouched", mem[32'h300 >> 2], 32'h0);
    op("lw_after_rst", 1'b0, 2'b00, 1'b0, 32'h0000_0200, 32'h0, 32'hBEEF_2222, 1'b0, 3, -1, 32'h0);

    // Held start on the MEM_LAT=3 instance.
    bus3.start = 1'b1;
    s3 = cyc;
    mon3_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (n3 == 3) break;
    end
    bus3.start = 1'b0;
    mon3_en = 1'b0;
    chk("held_done_count", 32'(n3), 32'd3);

    repeat (8) @(posedge clk);
    #1;
    chk("held_idle", {31'h0, bus3.busy}, 32'h0);
    chk("sb_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("sb_wr_empty", 32'(wr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
